bcd_page_scheduler: RTL
=======================

# bcd_page_scheduler

Controller that sequences the binary-to-BCD converter and the three-digit seven-segment display. It requests a conversion, captures the nine-digit result as one consistent snapshot, and pages the snapshot onto three HEX digits in four frames (blank, high, mid, low), advancing on slow-clock ticks. It sits between the run/stop toggle logic, the BCD converter and the three BCD-to-7-segment decoders, and replaces ad-hoc paging driven directly from the divided clock.

## Interface

Parameters:
- DWELL_TICKS, 1: tick pulses each frame is held (legal range 1–255).
- TIMEOUT, 64: Clk cycles to wait for conv_done before abandoning a conversion (legal range 2–1023).
- BLANK_CODE, 4'hF: BCD code the decoders render as a dark digit.

Ports:
- Clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, asynchronous and active-high. All state and outputs are cleared immediately.
- run  in  1  level; 1 means keep cycling conversions and frames.
- tick  in  1  one-Clk-cycle strobe from the slow divider, synchronous to Clk.
- conv_start  out  1  one-cycle request pulse to the converter.
- conv_done  in  1  converter result valid; a one-cycle pulse or a level.
- bcd_in  in  36  nine BCD digits; [35:32] is the most significant.
- seg_digits  out  12  three digits to the decoders; [11:8] drives HEX2 and [3:0] drives HEX0.
- page  out  2  current frame: 0 = blank, 1 = high, 2 = mid, 3 = low.
- busy  out  1  1 in any state other than IDLE.
- err  out  1  sticky conversion-timeout flag; cleared only by rst.

## Operation

- State machine states: IDLE, CONVERT, SHOW_BLANK, SHOW_HI, SHOW_MID, SHOW_LO.
- **IDLE**
  - Outputs hold their last values.
  - run = 1 moves to CONVERT.
- **CONVERT**
  - conv_start is 1 during the first CONVERT cycle only.
  - A wait counter starts at 0 and increments every cycle.
  - conv_done = 1: capture bcd_in into the 36-bit snapshot and move to SHOW_BLANK.
  - Counter reaches TIMEOUT-1 without conv_done: set err, keep the previous snapshot, move to SHOW_BLANK.
- **SHOW states**
  - Each SHOW state loads seg_digits and page on entry and clears the dwell counter.
  - Each tick increments the dwell counter.
  - A tick while the dwell counter equals DWELL_TICKS-1 advances the state: BLANK → HI → MID → LO.
- **Frame contents**
  - SHOW_BLANK: seg_digits = {3{BLANK_CODE}}, page = 0.
  - SHOW_HI: seg_digits = snapshot[35:24], page = 1.
  - SHOW_MID: seg_digits = snapshot[23:12], page = 2.
  - SHOW_LO: seg_digits = snapshot[11:0], page = 3.
- **Leaving SHOW_LO**
  - On the advancing tick, run is sampled.
  - run = 1: go to CONVERT.
  - run = 0: go to IDLE; seg_digits keeps the low digits.
- run is ignored at every other point, so a frame sequence always completes.
- conv_done outside CONVERT is ignored.
- tick outside the SHOW states is ignored.
- Snapshot digits pass through unchecked, so codes 10–15 reach the decoders unchanged.
- Reset values:
  - state IDLE
  - seg_digits 12'hFFF
  - page 0
  - conv_start 0
  - busy 0
  - err 0
  - snapshot 0
  - dwell and wait counters 0

## Timing

- All outputs are registered.
- State change and output update happen on the same Clk edge.
- run rises in IDLE at edge N-1:
  - At edge N: state is CONVERT and conv_start = 1.
  - At edge N+1: conv_start = 0.
- conv_done is high in cycle M, inside CONVERT:
  - At edge M+1: snapshot is loaded, state is SHOW_BLANK, seg_digits = FFF, page = 0.
  - Latency from run to first blank frame = 2 + converter latency.
- conv_done in the same cycle as conv_start is accepted.
- Timeout with conv_done asserted on the expiring cycle counts as done; err stays 0.
- tick and conv_done in the same CONVERT cycle: tick is discarded, and the dwell count starts fresh in SHOW_BLANK.
- A tick in the cycle a SHOW state is entered counts as the first tick of that frame.
- Frame period = DWELL_TICKS ticks.
- Full cycle = 4·DWELL_TICKS ticks plus the conversion time.
- rst asserted mid-operation: all outputs take their reset values asynchronously, and conv_start drops within the same cycle.
- After rst releases, the block runs again from IDLE on the first edge with run = 1.

## Test plan

- **Reset:**
  - Stimulus: assert rst mid-SHOW_MID with conv_start idle.
  - Required: seg_digits = FFF, page = 0, busy = 0, err = 0 immediately, with no Clk edge needed.
- **Single cycle:**
  - Stimulus: DWELL_TICKS = 1; run = 1; converter returns conv_done 5 cycles after conv_start with bcd_in = 36'h123456789.
  - Required frame sequence: FFF/0, 123/1, 456/2, 789/3, each lasting one tick.
  - Required: conv_start pulses exactly once per cycle.
- **Stop at boundary:**
  - Stimulus: drop run during SHOW_HI.
  - Required: MID and LO frames still appear, then the block is IDLE with seg_digits = 789, busy = 0, and no further conv_start.
- **Timeout:**
  - Stimulus: TIMEOUT = 8; conv_done never asserts.
  - Required: 8 cycles after conv_start, state is SHOW_BLANK, err = 1, and the previous snapshot is displayed.
  - Required: err is still 1 after the next successful conversion.
- **Dwell and coincident events:**
  - Stimulus: DWELL_TICKS = 3; tick asserted in the same cycle as conv_done.
  - Required: SHOW_BLANK lasts exactly 3 further ticks.
  - Required: conv_done pulses injected during SHOW states do not change the snapshot.

Source files
------------

// File: rtl/bcd_page_scheduler.sv
// bcd_page_scheduler: requests a BCD conversion, snapshots the nine-digit result
// and pages it onto three seven-segment digits as blank/high/mid/low frames.
module bcd_page_scheduler #(
    parameter int unsigned DWELL_TICKS = 1,
    parameter int unsigned TIMEOUT     = 64,
    parameter logic [3:0]  BLANK_CODE  = 4'hF
) (
    input  logic        Clk,
    input  logic        rst,
    input  logic        run,
    input  logic        tick,
    output logic        conv_start,
    input  logic        conv_done,
    input  logic [35:0] bcd_in,
    output logic [11:0] seg_digits,
    output logic [1:0]  page,
    output logic        busy,
    output logic        err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CONVERT = 3'd1;
    localparam logic [2:0] S_BLANK   = 3'd2;
    localparam logic [2:0] S_HI      = 3'd3;
    localparam logic [2:0] S_MID     = 3'd4;
    localparam logic [2:0] S_LO      = 3'd5;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL_TICKS - 1);
    localparam logic [9:0] WAIT_LAST  = 10'(TIMEOUT - 1);

    logic [2:0]  state;
    logic [7:0]  dwell_cnt;
    logic [9:0]  wait_cnt;
    logic [35:0] snapshot;
    logic        dwell_done;

    // A tick on the last dwell count is the one that moves to the next frame.
    assign dwell_done = tick && (dwell_cnt == DWELL_LAST);

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            seg_digits <= 12'hFFF;
            page       <= 2'd0;
            conv_start <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            snapshot   <= 36'd0;
            dwell_cnt  <= 8'd0;
            wait_cnt   <= 10'd0;
        end else begin
            conv_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state      <= S_CONVERT;
                        conv_start <= 1'b1;
                        wait_cnt   <= 10'd0;
                        busy       <= 1'b1;
                    end
                end
                S_CONVERT: begin
                    // A done on the expiring cycle wins over the timeout.
                    if (conv_done || (wait_cnt == WAIT_LAST)) begin
                        if (conv_done) begin
                            snapshot <= bcd_in;
                        end else begin
                            err <= 1'b1;
                        end
                        state      <= S_BLANK;
                        seg_digits <= {3{BLANK_CODE}};
                        page       <= 2'd0;
                        dwell_cnt  <= 8'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 10'd1;
                    end
                end
                S_BLANK: begin
                    if (dwell_done) begin
                        state      <= S_HI;
                        seg_digits <= snapshot[35:24];
                        page       <= 2'd1;
                        dwell_cnt  <= 8'd0;
                    end else if (tick) begin
                        dwell_cnt <= dwell_cnt + 8'd1;
                    end
                end
                S_HI: begin
                    if (dwell_done) begin
                        state      <= S_MID;
                        seg_digits <= snapshot[23:12];
                        page       <= 2'd2;
                        dwell_cnt  <= 8'd0;
                    end else if (tick) begin
                        dwell_cnt <= dwell_cnt + 8'd1;
                    end
                end
                S_MID: begin
                    if (dwell_done) begin
                        state      <= S_LO;
                        seg_digits <= snapshot[11:0];
                        page       <= 2'd3;
                        dwell_cnt  <= 8'd0;
                    end else if (tick) begin
                        dwell_cnt <= dwell_cnt + 8'd1;
                    end
                end
                S_LO: begin
                    // run is only consulted here, so a started sequence always completes.
                    if (dwell_done) begin
                        dwell_cnt <= 8'd0;
                        if (run) begin
                            state      <= S_CONVERT;
                            conv_start <= 1'b1;
                            wait_cnt   <= 10'd0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (tick) begin
                        dwell_cnt <= dwell_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
